// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin byte arbiter sharing one UART transmitter between
//                a CPU byte FIFO and a single-byte debug holding register.
//                Optional macro UART_ARB_FRAME_LOCK_EN keeps debug messages
//                contiguous while dbg_frame is high.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int FIFO_DEPTH   = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cpu_tx_start,
    input  logic [7:0]                    cpu_tx_data,
    output logic                          cpu_busy,
    input  logic                          dbg_tx_start,
    input  logic [7:0]                    dbg_tx_data,
    output logic                          dbg_busy,
`ifdef UART_ARB_FRAME_LOCK_EN
    input  logic                          dbg_frame,
`endif
    output logic                          uart_tx_start,
    output logic [7:0]                    uart_tx_data,
    input  logic                          uart_tx_busy,
    output logic                          grant_dbg,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    overflow
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(FIFO_DEPTH);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_CW-1:0]     r_count;
    logic [c_CW-1:0]     w_count_next;
    logic                r_cpu_busy;
    logic [7:0]          r_dbg_data;
    logic                r_dbg_busy;
    logic [7:0]          r_tx_data;
    logic                r_grant_dbg;
    logic [1:0]          r_overflow;
    logic [c_TW-1:0]     r_to_cnt;
    logic                w_push;
    logic                w_dbg_load;
    logic                w_grant_cpu;
    logic                w_grant_dbg;
    logic                w_lock;

    // Fullness uses the registered count, so a push into a full FIFO is lost
    // even when the arbiter pops in the same cycle.
    assign w_push       = cpu_tx_start && (r_count != c_FULL);
    assign w_dbg_load   = dbg_tx_start && !r_dbg_busy;
    assign w_count_next = r_count + {{(c_CW-1){1'b0}}, w_push}
                                  - {{(c_CW-1){1'b0}}, w_grant_cpu};

`ifdef UART_ARB_FRAME_LOCK_EN
    assign w_lock = dbg_frame && r_grant_dbg;
`else
    assign w_lock = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_grant_cpu  = 1'b0;
        w_grant_dbg  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!uart_tx_busy) begin
                    if (w_lock) begin
                        w_grant_dbg = r_dbg_busy;
                    end else if ((r_count != '0) && r_dbg_busy) begin
                        // Contention: the source that did not win last time goes next.
                        w_grant_dbg = !r_grant_dbg;
                        w_grant_cpu = r_grant_dbg;
                    end else begin
                        w_grant_cpu = (r_count != '0);
                        w_grant_dbg = r_dbg_busy;
                    end
                    if (w_grant_cpu || w_grant_dbg) begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE:     w_state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cpu_busy  <= 1'b0;
            r_dbg_data  <= 8'h00;
            r_dbg_busy  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_grant_dbg <= 1'b0;
            r_overflow  <= 2'b00;
            r_to_cnt    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_cpu_busy <= (w_count_next == c_FULL);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_grant_cpu) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (cpu_tx_start && !w_push) begin
                r_overflow[0] <= 1'b1;
            end
            if (dbg_tx_start && r_dbg_busy) begin
                r_overflow[1] <= 1'b1;
            end
            if (w_dbg_load) begin
                r_dbg_data <= dbg_tx_data;
                r_dbg_busy <= 1'b1;
            end else if (w_grant_dbg) begin
                r_dbg_busy <= 1'b0;
            end
            if (w_grant_cpu || w_grant_dbg) begin
                r_grant_dbg <= w_grant_dbg;
                r_tx_data   <= w_grant_dbg ? r_dbg_data : r_mem[r_rd_ptr];
            end
            if (r_state == S_WAIT_BUSY) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cpu_tx_data;
        end
    end

    assign cpu_busy      = r_cpu_busy;
    assign dbg_busy      = r_dbg_busy;
    assign uart_tx_start = (r_state == S_ISSUE);
    assign uart_tx_data  = r_tx_data;
    assign grant_dbg     = r_grant_dbg;
    assign fifo_count    = r_count;
    assign overflow      = r_overflow;

endmodule

`default_nettype wire
